// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: timeout FSM states, character
// lengths in 16x ticks and the bit layout of the frame configuration word.
package uart_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    WAIT    = 2'd1,
    TIMEOUT = 2'd2
  } to_state_e;

  // One character time in 16x ticks: start + 8 data + stop, plus parity.
  localparam int unsigned CHAR_TICKS_NOPAR = 160;
  localparam int unsigned CHAR_TICKS_PAR   = 176;

  localparam int unsigned CFG_MSB_FIRST = 0;
  localparam int unsigned CFG_PARITY_EN = 1;
  localparam int unsigned CFG_START_POL = 2;

  localparam int unsigned CNT_W = 10;

  function automatic logic [CNT_W-1:0] timeout_limit(input int unsigned chars,
                                                     input logic        parity_en);
    int unsigned ticks;
    ticks = chars * (parity_en ? CHAR_TICKS_PAR : CHAR_TICKS_NOPAR);
    return CNT_W'(ticks);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with synchronous flush; a push is accepted on a full
// FIFO only when a pop retires an entry in the same cycle.
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          push_acc_o,
  output logic          pop_acc_o,
  output logic [AW:0]   level_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;

  assign empty_o    = (level_q == '0);
  assign full_o     = (level_q == (AW+1)'(DEPTH));
  assign pop_acc_o  = pop_i & ~empty_o & ~flush_i;
  assign push_acc_o = push_i & ~flush_i & (~full_o | pop_acc_o);
  assign head_o     = mem_q[rd_ptr_q];
  assign level_o    = level_q;

  // NOTE: the storage array has no reset; only pointers and level need a known
  // value, and leaving it out keeps the array mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (push_acc_o) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_acc_o) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_acc_o)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_acc_o, pop_acc_o})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: byte FIFO, receiver frame config, character timeout
// FSM and combined interrupt. Build macro UART_RX_CTRL_STATS_EN adds counters.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int AW            = 4,
  parameter int TIMEOUT_CHARS = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_16x_baud_i,
  input  logic          rx_strobe_i,
  input  logic [7:0]    rx_data_i,
  input  logic          cfg_wr_i,
  input  logic [2:0]    cfg_wdata_i,
  output logic          msb_first_o,
  output logic          parity_en_o,
  output logic          start_polarity_o,
  input  logic          rd_en_i,
  output logic [7:0]    rd_data_o,
  output logic          rd_valid_o,
  output logic [AW:0]   level_o,
  input  logic [AW:0]   thresh_i,
  input  logic          clr_ovr_i,
  output logic          overrun_o,
  output logic          timeout_o,
`ifdef UART_RX_CTRL_STATS_EN
  output logic [15:0]   stat_rx_cnt_o,
  output logic [15:0]   stat_drop_cnt_o,
`endif
  output logic          irq_o
);

  logic [2:0]       cfg_q;
  logic [7:0]       rd_data_q;
  logic             rd_valid_q, ovr_q, irq_q;
  to_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, limit;
  logic [7:0]       head;
  logic             full, empty, push_acc, pop_acc, drop, last_pop;

  uart_sync_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (cfg_wr_i),
    .push_i     (rx_strobe_i),
    .pop_i      (rd_en_i),
    .wdata_i    (rx_data_i),
    .head_o     (head),
    .full_o     (full),
    .empty_o    (empty),
    .push_acc_o (push_acc),
    .pop_acc_o  (pop_acc),
    .level_o    (level_o)
  );

  assign drop     = rx_strobe_i & ~cfg_wr_i & full & ~pop_acc;
  assign last_pop = pop_acc & ~push_acc & (level_o == (AW+1)'(1));
  assign limit    = timeout_limit(TIMEOUT_CHARS, cfg_q[CFG_PARITY_EN]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      if (cfg_wr_i) cfg_q <= cfg_wdata_i;
      if (pop_acc)  rd_data_q <= head;
      rd_valid_q <= pop_acc;
      ovr_q      <= (clr_ovr_i | cfg_wr_i) ? 1'b0 : (ovr_q | drop);
      irq_q      <= ((thresh_i != '0) && (level_o >= thresh_i)) | timeout_o | ovr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: defaults first so every path assigns state_d/cnt_d and no latch forms.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (cfg_wr_i) begin
      state_d = EMPTY;
      cnt_d   = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          cnt_d = '0;
          if (push_acc) state_d = WAIT;
        end
        WAIT: begin
          if (push_acc || pop_acc) begin
            cnt_d = '0;
            if (last_pop) state_d = EMPTY;
          end else if (en_16x_baud_i) begin
            if (cnt_q == limit - 1'b1) begin
              state_d = TIMEOUT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        TIMEOUT: begin
          if (push_acc || pop_acc) begin
            cnt_d   = '0;
            state_d = last_pop ? EMPTY : WAIT;
          end
        end
        default: begin
          state_d = EMPTY;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    timeout_o = (state_q == TIMEOUT);
  end

  assign msb_first_o      = cfg_q[CFG_MSB_FIRST];
  assign parity_en_o      = cfg_q[CFG_PARITY_EN];
  assign start_polarity_o = cfg_q[CFG_START_POL];
  assign rd_data_o        = rd_data_q;
  assign rd_valid_o       = rd_valid_q;
  assign overrun_o        = ovr_q;
  assign irq_o            = irq_q;

`ifdef UART_RX_CTRL_STATS_EN
  logic [15:0] rx_cnt_q, drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else if (cfg_wr_i) begin
      rx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (push_acc && rx_cnt_q != 16'hFFFF)   rx_cnt_q   <= rx_cnt_q + 1'b1;
      if (drop && drop_cnt_q != 16'hFFFF)     drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign stat_rx_cnt_o   = rx_cnt_q;
  assign stat_drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: accepted bytes are queued when driven and
// compared against rd_data_o whenever rd_valid_o is seen.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en_16x_baud_i = 1'b0;
  logic          rx_strobe_i = 1'b0;
  logic [7:0]    rx_data_i = '0;
  logic          cfg_wr_i = 1'b0;
  logic [2:0]    cfg_wdata_i = '0;
  logic          msb_first_o, parity_en_o, start_polarity_o;
  logic          rd_en_i = 1'b0;
  logic [7:0]    rd_data_o;
  logic          rd_valid_o;
  logic [AW:0]   level_o;
  logic [AW:0]   thresh_i = '0;
  logic          clr_ovr_i = 1'b0;
  logic          overrun_o, timeout_o, irq_o;
`ifdef UART_RX_CTRL_STATS_EN
  logic [15:0]   stat_rx_cnt_o, stat_drop_cnt_o;
`endif

  uart_rx_ctrl #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT_CHARS(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .en_16x_baud_i    (en_16x_baud_i),
    .rx_strobe_i      (rx_strobe_i),
    .rx_data_i        (rx_data_i),
    .cfg_wr_i         (cfg_wr_i),
    .cfg_wdata_i      (cfg_wdata_i),
    .msb_first_o      (msb_first_o),
    .parity_en_o      (parity_en_o),
    .start_polarity_o (start_polarity_o),
    .rd_en_i          (rd_en_i),
    .rd_data_o        (rd_data_o),
    .rd_valid_o       (rd_valid_o),
    .level_o          (level_o),
    .thresh_i         (thresh_i),
    .clr_ovr_i        (clr_ovr_i),
    .overrun_o        (overrun_o),
    .timeout_o        (timeout_o),
`ifdef UART_RX_CTRL_STATS_EN
    .stat_rx_cnt_o    (stat_rx_cnt_o),
    .stat_drop_cnt_o  (stat_drop_cnt_o),
`endif
    .irq_o            (irq_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input bit accepted);
    rx_strobe_i = 1'b1;
    rx_data_i   = b;
    step();
    rx_strobe_i = 1'b0;
    if (accepted) exp_q.push_back(b);
  endtask

  task automatic pop();
    rd_en_i = 1'b1;
    step();
    rd_en_i = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      en_16x_baud_i = 1'b1;
      step();
      en_16x_baud_i = 1'b0;
      step();
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_level"},   32'(level_o), 0);
    check({tag, "_irq"},     32'(irq_o), 0);
    check({tag, "_valid"},   32'(rd_valid_o), 0);
    check({tag, "_data"},    32'(rd_data_o), 0);
    check({tag, "_ovr"},     32'(overrun_o), 0);
    check({tag, "_tmo"},     32'(timeout_o), 0);
    check({tag, "_cfg"},     32'({start_polarity_o, parity_en_o, msb_first_o}), 0);
  endtask

  // Scoreboard: every pop the DUT reports must match the oldest queued byte.
  always @(negedge clk) begin
    if (rst_n && rd_valid_o) begin
      if (exp_q.size() == 0) check("sb_underflow", 1, 0);
      else                   check("rd_data", 32'(rd_data_o), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check_idle_outputs("reset");

    // Two bytes in, two out, level tracking.
    push(8'hA5, 1);
    push(8'h3C, 1);
    check("lvl_2", 32'(level_o), 2);
    pop();
    check("lvl_1", 32'(level_o), 1);
    check("valid_1", 32'(rd_valid_o), 1);
    pop();
    check("lvl_0", 32'(level_o), 0);
    step();
    check("valid_pulse", 32'(rd_valid_o), 0);
    check("data_hold", 32'(rd_data_o), 32'h3C);
    pop();
    check("pop_empty_valid", 32'(rd_valid_o), 0);

    // Fill past capacity.
    for (int i = 0; i < DEPTH; i++) push(8'(8'h10 + i), 1);
    check("full_no_ovr", 32'(overrun_o), 0);
    push(8'hEE, 0);
    check("full_lvl", 32'(level_o), DEPTH);
    check("ovr_set", 32'(overrun_o), 1);
    step();
    check("ovr_irq", 32'(irq_o), 1);
    clr_ovr_i = 1'b1;
    step();
    clr_ovr_i = 1'b0;
    check("ovr_clr", 32'(overrun_o), 0);

    // Push and pop together on a full FIFO.
    rx_strobe_i = 1'b1;
    rx_data_i   = 8'h77;
    rd_en_i     = 1'b1;
    step();
    rx_strobe_i = 1'b0;
    rd_en_i     = 1'b0;
    exp_q.push_back(8'h77);
    check("pp_full_lvl", 32'(level_o), DEPTH);
    check("pp_full_ovr", 32'(overrun_o), 0);
    for (int i = 0; i < DEPTH; i++) pop();
    check("drain_lvl", 32'(level_o), 0);
    step();

    // Character timeout without parity: 4 * 160 ticks.
    push(8'h5A, 1);
    ticks(639);
    check("tmo_early", 32'(timeout_o), 0);
    en_16x_baud_i = 1'b1;
    step();
    en_16x_baud_i = 1'b0;
    check("tmo_640", 32'(timeout_o), 1);
    check("tmo_irq_lag", 32'(irq_o), 0);
    step();
    check("tmo_irq", 32'(irq_o), 1);
    pop();
    check("tmo_clr", 32'(timeout_o), 0);
    check("tmo_lvl", 32'(level_o), 0);
    step();
    check("tmo_irq_clr", 32'(irq_o), 0);

    // Level threshold, then a config write that flushes.
    thresh_i = 5'd4;
    for (int i = 0; i < 4; i++) push(8'(8'hC0 + i), 1);
    check("thr_lvl", 32'(level_o), 4);
    check("thr_irq_lag", 32'(irq_o), 0);
    step();
    check("thr_irq", 32'(irq_o), 1);
    cfg_wr_i    = 1'b1;
    cfg_wdata_i = 3'b110;
    rx_strobe_i = 1'b1;
    rx_data_i   = 8'h99;
    step();
    cfg_wr_i    = 1'b0;
    rx_strobe_i = 1'b0;
    exp_q.delete();
    check("cfg_flush", 32'(level_o), 0);
    check("cfg_bits", 32'({start_polarity_o, parity_en_o, msb_first_o}), 32'b110);
    thresh_i = '0;
    step();
    check("cfg_irq_clr", 32'(irq_o), 0);

    // Character timeout with parity: 4 * 176 ticks.
    push(8'h42, 1);
    ticks(703);
    check("ptmo_early", 32'(timeout_o), 0);
    ticks(1);
    check("ptmo_704", 32'(timeout_o), 1);
    pop();
    check("ptmo_clr", 32'(timeout_o), 0);
    step();

    // Asynchronous reset mid-frame with five bytes queued.
    for (int i = 0; i < 5; i++) push(8'(8'h60 + i), 1);
    check("pre_rst_lvl", 32'(level_o), 5);
    rx_strobe_i = 1'b1;
    rx_data_i   = 8'hFF;
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_async_lvl", 32'(level_o), 0);
    rx_strobe_i = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check_idle_outputs("rst_mid");

    check("sb_left", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
